// File: rtl/vga_timing_out.sv
// Pixel-clock raster engine: scan counters for draw_field, sync/de delay line, registered VGA pins.
// Optional colour-bar source replaces draw_field data when VGA_TIMING_TEST_PATTERN_EN is defined.
module vga_timing_out #(
    parameter int unsigned PIX_WIDTH = 12,
    parameter int unsigned H_ACTIVE  = 1280,
    parameter int unsigned H_FP      = 48,
    parameter int unsigned H_SYNC    = 112,
    parameter int unsigned H_BP      = 248,
    parameter int unsigned V_ACTIVE  = 1024,
    parameter int unsigned V_FP      = 1,
    parameter int unsigned V_SYNC    = 3,
    parameter int unsigned V_BP      = 38,
    parameter bit          HS_POL    = 1'b1,
    parameter bit          VS_POL    = 1'b1,
    parameter int unsigned DRAW_LAT  = 1,
    parameter logic [23:0] BG_COLOR  = 24'h000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PIX_WIDTH-1:0] pix_x_o,
    output logic [PIX_WIDTH-1:0] pix_y_o,
    output logic                 frame_start_o,
    input  logic [23:0]          vga_data_i,
    input  logic                 vga_data_en_i,
    output logic [7:0]           vga_r_o,
    output logic [7:0]           vga_g_o,
    output logic [7:0]           vga_b_o,
    output logic                 vga_hs_o,
    output logic                 vga_vs_o,
    output logic                 vga_de_o
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [PIX_WIDTH-1:0] H_LAST = PIX_WIDTH'(H_TOT - 1);
    localparam logic [PIX_WIDTH-1:0] V_LAST = PIX_WIDTH'(V_TOT - 1);
    localparam logic [PIX_WIDTH-1:0] H_ACT  = PIX_WIDTH'(H_ACTIVE);
    localparam logic [PIX_WIDTH-1:0] V_ACT  = PIX_WIDTH'(V_ACTIVE);
    localparam logic [PIX_WIDTH-1:0] HS_BEG = PIX_WIDTH'(H_ACTIVE + H_FP);
    localparam logic [PIX_WIDTH-1:0] HS_END = PIX_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [PIX_WIDTH-1:0] VS_BEG = PIX_WIDTH'(V_ACTIVE + V_FP);
    localparam logic [PIX_WIDTH-1:0] VS_END = PIX_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

    logic                 run_q, run_d;
    logic [PIX_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic                 fs_q, fs_d;
    logic                 de0, hs0, vs0;
    logic                 de_dly, hs_dly, vs_dly;
    logic [23:0]          rgb_q, rgb_d;
    logic                 hs_q, vs_q, de_q;

    // The first edge after release only arms the raster, so (0,0) is held for one full cycle.
    always_comb begin
        run_d = 1'b1;
        x_d   = x_q;
        y_d   = y_q;
        if (run_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + PIX_WIDTH'(1);
            end else begin
                x_d = x_q + PIX_WIDTH'(1);
            end
        end
        fs_d = (x_d == '0) && (y_d == '0);
    end

    always_comb begin
        de0 = run_q && (x_q < H_ACT) && (y_q < V_ACT);
        hs0 = ((x_q >= HS_BEG) && (x_q < HS_END)) ? HS_POL : ~HS_POL;
        vs0 = ((y_q >= VS_BEG) && (y_q < VS_END)) ? VS_POL : ~VS_POL;
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [PIX_WIDTH-1:0] x_dly;
`endif

    if (DRAW_LAT == 0) begin : g_pass
        assign de_dly = de0;
        assign hs_dly = hs0;
        assign vs_dly = vs0;
`ifdef VGA_TIMING_TEST_PATTERN_EN
        assign x_dly  = x_q;
`endif
    end else begin : g_dly
        logic [DRAW_LAT-1:0] de_sh_q, de_sh_d, hs_sh_q, hs_sh_d, vs_sh_q, vs_sh_d;

        always_comb begin
            de_sh_d = (de_sh_q << 1) | DRAW_LAT'(de0);
            hs_sh_d = (hs_sh_q << 1) | DRAW_LAT'(hs0);
            vs_sh_d = (vs_sh_q << 1) | DRAW_LAT'(vs0);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                de_sh_q <= '0;
                hs_sh_q <= {DRAW_LAT{~HS_POL}};
                vs_sh_q <= {DRAW_LAT{~VS_POL}};
            end else begin
                de_sh_q <= de_sh_d;
                hs_sh_q <= hs_sh_d;
                vs_sh_q <= vs_sh_d;
            end
        end

        assign de_dly = de_sh_q[DRAW_LAT-1];
        assign hs_dly = hs_sh_q[DRAW_LAT-1];
        assign vs_dly = vs_sh_q[DRAW_LAT-1];

`ifdef VGA_TIMING_TEST_PATTERN_EN
        logic [PIX_WIDTH-1:0] x_sh_q [DRAW_LAT];
        logic [PIX_WIDTH-1:0] x_sh_d [DRAW_LAT];

        always_comb begin
            x_sh_d[0] = x_q;
            for (int i = 1; i < int'(DRAW_LAT); i++) x_sh_d[i] = x_sh_q[i-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(DRAW_LAT); i++) x_sh_q[i] <= '0;
            end else begin
                for (int i = 0; i < int'(DRAW_LAT); i++) x_sh_q[i] <= x_sh_d[i];
            end
        end

        assign x_dly = x_sh_q[DRAW_LAT-1];
`endif
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int unsigned BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic                 unused_draw_in;
    logic [PIX_WIDTH-1:0] bar_full;
    logic [2:0]           bar;
    logic [23:0]          bar_rgb;

    assign unused_draw_in = ^{vga_data_i, vga_data_en_i};

    // Bar index bits map straight to channel enables: R=!b1, G=!b2, B=!b0.
    always_comb begin
        bar_full = x_dly / PIX_WIDTH'(BAR_W);
        bar      = (bar_full > PIX_WIDTH'(7)) ? 3'd7 : bar_full[2:0];
        bar_rgb  = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
    end
`endif

    always_comb begin
        rgb_d = 24'h0;
        if (de_dly) begin
`ifdef VGA_TIMING_TEST_PATTERN_EN
            rgb_d = bar_rgb;
`else
            rgb_d = vga_data_en_i ? vga_data_i : BG_COLOR;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            fs_q  <= 1'b0;
            rgb_q <= 24'h0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
        end else begin
            run_q <= run_d;
            x_q   <= x_d;
            y_q   <= y_d;
            fs_q  <= fs_d;
            rgb_q <= rgb_d;
            hs_q  <= hs_dly;
            vs_q  <= vs_dly;
            de_q  <= de_dly;
        end
    end

    assign pix_x_o       = x_q;
    assign pix_y_o       = y_q;
    assign frame_start_o = fs_q;
    assign vga_r_o       = rgb_q[23:16];
    assign vga_g_o       = rgb_q[15:8];
    assign vga_b_o       = rgb_q[7:0];
    assign vga_hs_o      = hs_q;
    assign vga_vs_o      = vs_q;
    assign vga_de_o      = de_q;

endmodule

// File: doc/vga_timing_out.md
Name: vga_timing_out

Overview:
- Pixel-clock raster engine sitting on both sides of draw_field.
- Upstream role: generates the pix_x/pix_y scan position that draw_field consumes.
- Downstream role: takes draw_field's vga_data_o/vga_data_en_o, merges them with a background colour, and drives the registered VGA pins (RGB, hsync, vsync, de).
- Delays the sync/de signals internally so they line up with draw_field's pipeline latency.
- Also gives game logic a once-per-frame strobe.

Parameters:
- PIX_WIDTH, 12, width of the pixel coordinate buses.
- H_ACTIVE, 1280, visible pixels per line.
- H_FP, 48, horizontal front porch in clocks.
- H_SYNC, 112, hsync pulse width in clocks.
- H_BP, 248, horizontal back porch in clocks.
- V_ACTIVE, 1024, visible lines per frame.
- V_FP, 1, vertical front porch in lines.
- V_SYNC, 3, vsync pulse width in lines.
- V_BP, 38, vertical back porch in lines.
- HS_POL, 1, hsync active level.
- VS_POL, 1, vsync active level.
- DRAW_LAT, 1, clocks from pix_x_o/pix_y_o to valid vga_data_i; legal range 0..7.
- BG_COLOR, 24'h000000, RGB shown in the active area when vga_data_en_i=0.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_x_o  out  PIX_WIDTH  current horizontal count, to draw_field pix_x_i.
- pix_y_o  out  PIX_WIDTH  current vertical count, to draw_field pix_y_i.
- frame_start_o  out  1  one-clock strobe at raster position (0,0).
- vga_data_i  in  24  RGB from draw_field.
- vga_data_en_i  in  1  draw_field pixel-valid.
- vga_r_o  out  8  red to DAC/HDMI.
- vga_g_o  out  8  green to DAC/HDMI.
- vga_b_o  out  8  blue to DAC/HDMI.
- vga_hs_o  out  1  hsync.
- vga_vs_o  out  1  vsync.
- vga_de_o  out  1  active-video enable.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Values held during reset:
  - pix_x_o=0, pix_y_o=0, frame_start_o=0.
  - RGB=0, vga_de_o=0.
  - vga_hs_o=!HS_POL, vga_vs_o=!VS_POL.
  - All delay-line stages hold their inactive values (de=0, syncs inactive).
- Counters:
  - H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - pix_x_o increments every clock and wraps H_TOT-1 -> 0.
  - On that wrap only, pix_y_o increments, wrapping V_TOT-1 -> 0.
  - The counters are registers and drive pix_x_o/pix_y_o directly.
  - The first clock after reset release shows (0,0).
- Stage-0 raw signals, derived combinationally from the counter registers:
  - de0 = (x<H_ACTIVE)&&(y<V_ACTIVE).
  - hs0 = HS_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else !HS_POL.
  - vs0 = VS_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, else !VS_POL. vs0 changes at the start of a line (x=0).
- frame_start_o:
  - Registered; high exactly in the cycle the counters read (0,0).
  - This includes the first cycle after reset release.
  - Period H_TOT*V_TOT clocks.
- Delay line:
  - de0/hs0/vs0 pass through a DRAW_LAT-deep shift register, giving de_d/hs_d/vs_d.
  - DRAW_LAT=0 means a pass-through.
- Output register, loaded every clock:
  - vga_hs_o=hs_d, vga_vs_o=vs_d, vga_de_o=de_d.
  - RGB = de_d ? (vga_data_en_i ? vga_data_i : BG_COLOR) : 24'h0.
  - Bits [23:16] go to R, [15:8] to G, [7:0] to B.
- Latency: counter value to pins = DRAW_LAT+1 clocks. Sync-to-data skew at the pins is zero.
- Blanking: RGB is forced to 0 whenever de_d=0, regardless of vga_data_en_i.
- Reset mid-frame:
  - All outputs return to reset values immediately (asynchronous).
  - The raster restarts at (0,0) after release, with frame_start_o asserted on that first cycle.
  - No partial line is replayed.
- Width rule: PIX_WIDTH must hold H_TOT-1 and V_TOT-1. With defaults, 1687 and 1065 fit in 12 bits.

Optional Feature:
- Macro: VGA_TIMING_TEST_PATTERN_EN.
- When defined:
  - vga_data_i and vga_data_en_i are ignored.
  - Active-area RGB comes from 8 vertical colour bars, each H_ACTIVE/8 wide.
  - Bar index is the delayed x divided by (H_ACTIVE/8).
  - Bar colours in order: white, yellow, cyan, green, magenta, red, blue, black (each channel 8'hFF or 8'h00).
  - An x delay line matching DRAW_LAT is added.
  - Timing, latency, blanking and frame_start_o are unchanged.
- When undefined: no extra logic; behaviour as above.

Test Plan:
- Reset held 10 clocks, then released:
  - During reset: hs=!HS_POL, vs=!VS_POL, de=0, RGB=0.
  - First post-release cycle: pix=(0,0), frame_start_o=1.
  - DRAW_LAT+1 clocks later: vga_de_o=1.
- Free-run one full frame:
  - hsync asserted exactly 112 clocks per line, starting at x=1328, seen at the pins at x=1328+DRAW_LAT+1.
  - vsync asserted 3 lines starting at y=1025.
  - frame_start_o period 1688*1066 = 1,799,408 clocks.
- Drive vga_data_en_i=1, vga_data_i=24'h12_34_56 only while delayed x is in [300,331]:
  - Pins show R=12 G=34 B=56 for 32 pixels.
  - All other active pixels show BG_COLOR.
- Drive vga_data_en_i=1, vga_data_i=24'hFFFFFF permanently: RGB is 0 during every blanking clock (de=0).
- Assert rst_n low mid-line at x=700, y=500:
  - Outputs go to reset values in the same cycle, without waiting for a clock edge.
  - After release, the raster resumes at (0,0).
- With VGA_TIMING_TEST_PATTERN_EN defined and default parameters:
  - Pixel x=0 is FFFFFF, x=160 is FFFF00, x=1279 is 000000.
  - Input data is ignored.
